// File: rtl/systolic_row_skewer_pkg.sv
// Shared types and defaults for the systolic row skewer feeder stage.
package systolic_pkg;

  localparam int DEFAULT_LANES  = 4;
  localparam int DEFAULT_DATA_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_e;

  typedef struct packed {
    logic                      valid;
    logic [DEFAULT_DATA_W-1:0] data;
  } lane_elem_t;

endpackage

// File: rtl/systolic_row_skewer_delay.sv
// Enable-gated shift register of {valid, data} elements, DEPTH stages deep,
// with asynchronous active-low clear.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 3
) (
  input  logic              clock,
  input  logic              clr_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  // Same shape as systolic_pkg::lane_elem_t, but sized by this instance's DATA_W.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } elem_t;

  elem_t [DEPTH-1:0] stage_q;
  elem_t [DEPTH-1:0] stage_d;

  // Shift on enable; stage 0 takes the new element or a zeroed bubble.
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0].valid = in_valid;
      stage_d[0].data  = in_valid ? in_data : {DATA_W{1'b0}};
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end else begin
      stage_d = stage_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_data  = stage_q[DEPTH-1].data;

endmodule

// File: rtl/systolic_row_skewer.sv
// Diagonal skew feeder for a systolic PE array: lane i is delayed i+1 steps.
// Optional stall statistics counter enabled by SYSTOLIC_SKEW_STATS_EN.
module systolic_row_skewer
  import systolic_pkg::*;
#(
  parameter int LANES  = DEFAULT_LANES,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    busy,
  output logic                    done
`ifdef SYSTOLIC_SKEW_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int               CNT_W    = $clog2(LANES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LANES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  skew_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_s;
  logic             accept_s;

  assign step_s   = out_ready;
  assign in_ready = out_ready && (state_q != DRAIN);
  assign accept_s = in_valid && in_ready;

  // Stream tracking: a last vector starts a LANES-step drain of the skew pipe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (step_s) begin
      case (state_q)
        IDLE, STREAM: begin
          if (accept_s && in_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_LOAD;
          end else if (accept_s) begin
            state_d = STREAM;
          end else begin
            state_d = state_q;
          end
        end
        DRAIN: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // FSM state and drain counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DRAIN) && (cnt_q == CNT_ZERO);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_delay (
      .clock     (clock),
      .clr_n     (reset),
      .en        (step_s),
      .in_valid  (accept_s),
      .in_data   (in_data[i*DATA_W +: DATA_W]),
      .out_valid (out_valid[i]),
      .out_data  (out_data[i*DATA_W +: DATA_W])
    );
  end

`ifdef SYSTOLIC_SKEW_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where upstream offers a vector we refuse.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      stall_cnt_d = 16'h0000;
    end else if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_row_skewer.sv
// Self-checking bench for systolic_row_skewer; covers SYSTOLIC_SKEW_STATS_EN when defined.
module tb_systolic_row_skewer;

  localparam int LANES = 4;
  localparam int W     = 3;
  localparam int VW    = LANES * W;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [VW-1:0]     in_data;
  logic              in_last;
  logic              out_ready;
  logic [LANES-1:0]  out_valid;
  logic [VW-1:0]     out_data;
  logic              busy;
  logic              done;
`ifdef SYSTOLIC_SKEW_STATS_EN
  logic              stats_clr;
  logic [15:0]       stall_cnt;
  int                m_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one history entry per global step (accepted vector or bubble).
  bit            hist_v[$];
  logic [VW-1:0] hist_d[$];
  int            m_last_idx;
  bit            m_in_stream;

  systolic_row_skewer #(.LANES(LANES), .DATA_W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
`ifdef SYSTOLIC_SKEW_STATS_EN
    ,
    .stats_clr (stats_clr),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_draining();
    int n = hist_v.size();
    return (m_last_idx >= 0) && (n >= m_last_idx + 1) && (n <= m_last_idx + LANES);
  endfunction

  task automatic model_clear();
    hist_v.delete();
    hist_d.delete();
    m_last_idx  = -1;
    m_in_stream = 1'b0;
`ifdef SYSTOLIC_SKEW_STATS_EN
    m_stall = 0;
`endif
  endtask

  task automatic check_outputs();
    logic [LANES-1:0] ev;
    logic [VW-1:0]    ed;
    int               n = hist_v.size();
    ev = '0;
    ed = '0;
    for (int i = 0; i < LANES; i++) begin
      if (n - 1 - i >= 0) begin
        ev[i]       = hist_v[n-1-i];
        ed[i*W +: W] = hist_d[n-1-i][i*W +: W];
      end
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data",  32'(out_data),  32'(ed));
    chk("busy", 32'(busy), 32'(m_in_stream || m_draining()));
    chk("done", 32'(done), 32'((m_last_idx >= 0) && (n == m_last_idx + LANES)));
`ifdef SYSTOLIC_SKEW_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  // One clock: drive at negedge, check in_ready, update model at posedge, check at negedge.
  task automatic cycle(input logic iv, input logic [VW-1:0] d, input logic lst, input logic ordy);
    logic exp_ready;
    logic acc;
    in_valid  = iv;
    in_data   = d;
    in_last   = lst;
    out_ready = ordy;
    #1;
    exp_ready = ordy && !m_draining();
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = iv && exp_ready;
    @(posedge clock);
`ifdef SYSTOLIC_SKEW_STATS_EN
    if (stats_clr) m_stall = 0;
    else if (iv && !exp_ready && m_stall < 65535) m_stall++;
`endif
    if (ordy) begin
      if (acc && lst) begin
        m_last_idx  = hist_v.size();
        m_in_stream = 1'b0;
      end else if (acc) begin
        m_in_stream = 1'b1;
      end
      hist_v.push_back(acc);
      hist_d.push_back(acc ? d : '0);
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef SYSTOLIC_SKEW_STATS_EN
    stats_clr = 1'b0;
`endif
    model_clear();
    repeat (2) @(negedge clock);
    check_outputs();
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Single vector {lane0=1, lane1=2, lane2=3, lane3=4} with in_last.
    cycle(1'b1, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);

    // Back-to-back stream with a 2-cycle stall, then valid held during drain.
    cycle(1'b1, 12'h249, 1'b0, 1'b1);
    cycle(1'b1, 12'h492, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 12'h6DB, 1'b1, 1'b0);
    cycle(1'b1, 12'h6DB, 1'b1, 1'b1);
    repeat (5) cycle(1'b1, VW'($urandom), 1'b1, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset in the middle of a drain, then a fresh single vector.
    cycle(1'b1, 12'h0AB, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    async_reset();
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), VW'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) != 0));
    end
    repeat (LANES + 2) cycle(1'b0, '0, 1'b0, 1'b1);

`ifdef SYSTOLIC_SKEW_STATS_EN
    stats_clr = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);
    stats_clr = 1'b0;
    repeat (5) cycle(1'b1, 12'h123, 1'b0, 1'b0);
    chk("stall_cnt_5", 32'(stall_cnt), 32'd5);
    stats_clr = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);
    stats_clr = 1'b0;
    chk("stall_cnt_clr", 32'(stall_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_row_skewer.md
Name: systolic_row_skewer

Overview:
- Downstream feeder stage between the lane pass-through/wrapper stage and the systolic PE array.
- Accepts one vector of LANES small elements per handshake and emits each lane diagonally skewed: lane i is delayed i+1 accepted steps.
- This gives the wavefront timing the PE grid needs.
- Tracks a vector stream ending in in_last, drains the skew pipeline, and pulses done when the last element leaves the last lane.

Parameters:
LANES, 4, number of lanes / PE rows fed (>=1)
DATA_W, 3, bits per lane element

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream vector valid
in_ready  out  1  stage can accept a vector this cycle
in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
in_last  in  1  qualifies the accepted vector as last of stream
out_ready  in  1  array advances this cycle (global step)
out_valid  out  LANES  per-lane element valid
out_data  out  LANES*DATA_W  skewed lane elements, same packing as in_data
busy  out  1  state != IDLE
done  out  1  last vector's lane LANES-1 element is on the output

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: all delay registers, out_valid and out_data are 0; state IDLE; drain counter 0; done 0.
- step = out_ready. When step=0, every register holds, including state and counter. Outputs remain stable.
- accept = in_valid && in_ready.
- in_ready = out_ready && state != DRAIN. This is combinational, with no dependency on in_valid.
- Lane i is a shift register of depth i+1 that advances only on step.
- Stage 0 of each lane loads {valid=1, in_data lane i} on accept. Otherwise it loads a bubble {valid=0, data=0}.
- Latency: lane i output shows an accepted element exactly i+1 steps after acceptance. There is no combinational in->out path.
- FSM states are IDLE, STREAM, DRAIN.
  - IDLE: accept && !in_last -> STREAM. accept && in_last -> DRAIN with cnt=LANES-1.
  - STREAM: accept && in_last -> DRAIN with cnt=LANES-1. Otherwise stay.
  - DRAIN: no acceptance. Each step with cnt>0 decrements cnt. cnt==0 && step -> IDLE.
- done = (state==DRAIN && cnt==0). It is combinational from registers and is held while out_ready=0.
- in_last is ignored unless accepted. in_valid in DRAIN is not accepted.
- IDLE with pipe still holding data: impossible by construction, since every stream ends via DRAIN.
- LANES=1: cnt loads 0, so done is asserted the cycle after acceptance.
- Reset mid-operation: all in-flight elements are discarded and state returns to IDLE immediately (async).
- cnt width: $clog2(LANES)+1 bits.

Optional Feature:
- Macro: SYSTOLIC_SKEW_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles with in_valid && !in_ready. Saturates at 16'hFFFF.
  - Cleared by reset.
  - Adds input stats_clr (1 = synchronous clear, takes priority over increment).
- Undefined: neither port exists and there is no counter logic. Core behaviour is identical.

Decomposition:
- Shared package systolic_pkg holds:
  - the skew_state_e enum (IDLE, STREAM, DRAIN);
  - the default LANES and DATA_W localparams;
  - the lane_elem_t typedef {valid, data}.
- Sub-module skew_delay_line:
  - parameters DEPTH, DATA_W; enable-gated shift of lane_elem_t; async active-low clear.
  - Instantiated per lane in a generate loop with DEPTH=i+1.

Test Plan:
- Reset: assert reset=0 mid-cycle -> out_valid=4'b0000, out_data=0, busy=0, done=0 asynchronously. With reset=1 and out_ready=1 -> in_ready=1.
- Single vector: lanes {1,2,3,4} (lane0=1) with in_last, out_ready=1 held.
  - Lane0=1 valid 1 cycle after accept; lane1=2 after 2; lane2=3 after 3; lane3=4 after 4.
  - done=1 in that 4th cycle only; then busy=0.
- Back-to-back stream: vectors {1,1,1,1},{2,2,2,2},{3,3,3,3} (last on 3rd), then out_ready=0 for 2 cycles after the 2nd accept.
  - Outputs and in_ready=0 hold during the stall.
  - Lane3 shows 1,2,3 on consecutive steps; done aligns with lane3=3.
- Drain backpressure: in_valid=1 during DRAIN -> in_ready=0, no extra vector appears on any lane.
- Reset mid-drain (cnt=2) -> pipe cleared, no done pulse. Next single vector behaves as in the single-vector test.
- SYSTOLIC_SKEW_STATS_EN: hold out_ready=0 with in_valid=1 for 5 cycles -> stall_cnt=5. stats_clr=1 -> stall_cnt=0 next cycle.
